// File: rtl/jala_stack_pkg.sv
// ----------------------------------------------------------------------------
// jala_stack_pkg
//   Shared constants and types for the JALA stack pointer unit.
//   - DATA_W               : pointer / address width
//   - MSP_BASE, RSP_BASE   : empty-stack pointer values (sentinel slots)
//   - MSP_DEPTH, RSP_DEPTH : maximum entry counts
//   - *_DEPTH_W            : depth counter widths (must hold 0..DEPTH)
//   - stack_op_t           : decoded per-edge stack operation
//   - decode_op()          : strobe-to-operation priority decode
// ----------------------------------------------------------------------------
package jala_stack_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] MSP_BASE = 16'h7FFF;
    localparam logic [DATA_W-1:0] RSP_BASE = 16'h7EFF;

    localparam int MSP_DEPTH = 256;
    localparam int RSP_DEPTH = 64;

    // The counter must represent DEPTH itself, hence DEPTH+1 states.
    localparam int MSP_DEPTH_W = $clog2(MSP_DEPTH + 1);
    localparam int RSP_DEPTH_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        PUSH   = 2'd1,
        POP    = 2'd2,
        RELOAD = 2'd3
    } stack_op_t;

    // Reload beats any write; a pop strobe only means something with write.
    function automatic stack_op_t decode_op(input logic write,
                                            input logic pop,
                                            input logic reg_reset);
        stack_op_t op;
        if (reg_reset)  op = RELOAD;
        else if (write) op = pop ? POP : PUSH;
        else            op = HOLD;
        return op;
    endfunction

endpackage

// File: rtl/stack_ptr_ctr.sv
// ----------------------------------------------------------------------------
// stack_ptr_ctr
//   One downward-growing stack pointer: pointer register, depth counter,
//   op decode and (optionally) a sticky fault bit.
//
//   Optional feature macro: STACK_FAULT_TRAP_EN
//     defined   : overflowing push / underflowing pop is suppressed and sets
//                 a sticky fault bit, cleared only by reg_reset or rst.
//     undefined : pointer always moves (wraps modulo 2^DATA_W), depth
//                 saturates at 0 / DEPTH, fault tied low.
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     write        in   enable a pointer update this cycle
//     pop          in   direction when write=1 (1 = pop, 0 = push)
//     reg_reset    in   synchronous reload to BASE (highest priority)
//     ptr          out  current top-of-stack address
//     push_addr    out  ptr-1, slot the next push occupies
//     second_addr  out  ptr+1, second stack entry
//     depth        out  live entry count
//     empty        out  depth == 0
//     fault        out  sticky overflow/underflow flag
// ----------------------------------------------------------------------------
module stack_ptr_ctr
    import jala_stack_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE    = MSP_BASE,
    parameter int                DEPTH   = MSP_DEPTH,
    parameter int                DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic               pop,
    input  logic               reg_reset,
    output logic [DATA_W-1:0]  ptr,
    output logic [DATA_W-1:0]  push_addr,
    output logic [DATA_W-1:0]  second_addr,
    output logic [DEPTH_W-1:0] depth,
    output logic               empty,
    output logic               fault
);

    stack_op_t          op;
    logic               full;
    logic               at_zero;
    logic [DATA_W-1:0]  ptr_d;
    logic [DEPTH_W-1:0] depth_d;

    always_comb begin
        op      = decode_op(write, pop, reg_reset);
        full    = (depth == DEPTH_W'(DEPTH));
        at_zero = (depth == '0);
        ptr_d   = ptr;
        depth_d = depth;
        case (op)
            RELOAD: begin
                ptr_d   = BASE;
                depth_d = '0;
            end
            PUSH: begin
`ifdef STACK_FAULT_TRAP_EN
                if (!full) begin
                    ptr_d   = ptr - DATA_W'(1);
                    depth_d = depth + DEPTH_W'(1);
                end
`else
                // Pointer moves regardless; only the count saturates.
                ptr_d = ptr - DATA_W'(1);
                if (!full) depth_d = depth + DEPTH_W'(1);
`endif
            end
            POP: begin
`ifdef STACK_FAULT_TRAP_EN
                if (!at_zero) begin
                    ptr_d   = ptr + DATA_W'(1);
                    depth_d = depth - DEPTH_W'(1);
                end
`else
                ptr_d = ptr + DATA_W'(1);
                if (!at_zero) depth_d = depth - DEPTH_W'(1);
`endif
            end
            default: begin
                ptr_d   = ptr;
                depth_d = depth;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= BASE;
            depth <= '0;
        end else begin
            ptr   <= ptr_d;
            depth <= depth_d;
        end
    end

`ifdef STACK_FAULT_TRAP_EN
    logic fault_q;
    logic fault_d;

    always_comb begin
        fault_d = fault_q;
        case (op)
            RELOAD:  fault_d = 1'b0;
            PUSH:    if (full)    fault_d = 1'b1;
            POP:     if (at_zero) fault_d = 1'b1;
            default: fault_d = fault_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Address outputs are pure functions of the registered pointer.
    assign push_addr   = ptr - DATA_W'(1);
    assign second_addr = ptr + DATA_W'(1);
    assign empty       = (depth == '0);

endmodule

// File: rtl/stack_pointer_unit.sv
// ----------------------------------------------------------------------------
// stack_pointer_unit
//   Main-stack (MSP) and return-stack (RSP) pointers for the JALA datapath.
//   Two independent stack_ptr_ctr instances; the only shared logic is the
//   StackFault OR.
//
//   Optional feature macro: STACK_FAULT_TRAP_EN (see stack_ptr_ctr).
//
//   Ports
//     CLK, Rst                          clock / async active-high reset
//     MSPWrite, MSPPop, MSPRegReset     main-stack strobes
//     RSPWrite, RSPPop, RSPRegReset     return-stack strobes
//     MSPAddr, MSPPushAddr, MSPSecondAddr   MSP, MSP-1, MSP+1
//     RSPAddr, RSPPushAddr              RSP, RSP-1
//     MSPDepth, RSPDepth                live entry counts
//     MSPEmpty, RSPEmpty                depth == 0
//     StackFault                        MSP fault | RSP fault
//
//   Handshake: strobes are sampled on every rising CLK edge with no
//   ready/back-pressure; results appear on the outputs the next cycle.
// ----------------------------------------------------------------------------
module stack_pointer_unit
    import jala_stack_pkg::*;
(
    input  logic                   CLK,
    input  logic                   Rst,
    input  logic                   MSPWrite,
    input  logic                   MSPPop,
    input  logic                   MSPRegReset,
    input  logic                   RSPWrite,
    input  logic                   RSPPop,
    input  logic                   RSPRegReset,
    output logic [DATA_W-1:0]      MSPAddr,
    output logic [DATA_W-1:0]      MSPPushAddr,
    output logic [DATA_W-1:0]      MSPSecondAddr,
    output logic [DATA_W-1:0]      RSPAddr,
    output logic [DATA_W-1:0]      RSPPushAddr,
    output logic [MSP_DEPTH_W-1:0] MSPDepth,
    output logic [RSP_DEPTH_W-1:0] RSPDepth,
    output logic                   MSPEmpty,
    output logic                   RSPEmpty,
    output logic                   StackFault
);

    logic              msp_fault;
    logic              rsp_fault;
    logic [DATA_W-1:0] rsp_second_addr;

    stack_ptr_ctr #(
        .BASE    (MSP_BASE),
        .DEPTH   (MSP_DEPTH),
        .DEPTH_W (MSP_DEPTH_W)
    ) u_msp (
        .clk         (CLK),
        .rst         (Rst),
        .write       (MSPWrite),
        .pop         (MSPPop),
        .reg_reset   (MSPRegReset),
        .ptr         (MSPAddr),
        .push_addr   (MSPPushAddr),
        .second_addr (MSPSecondAddr),
        .depth       (MSPDepth),
        .empty       (MSPEmpty),
        .fault       (msp_fault)
    );

    stack_ptr_ctr #(
        .BASE    (RSP_BASE),
        .DEPTH   (RSP_DEPTH),
        .DEPTH_W (RSP_DEPTH_W)
    ) u_rsp (
        .clk         (CLK),
        .rst         (Rst),
        .write       (RSPWrite),
        .pop         (RSPPop),
        .reg_reset   (RSPRegReset),
        .ptr         (RSPAddr),
        .push_addr   (RSPPushAddr),
        .second_addr (rsp_second_addr),
        .depth       (RSPDepth),
        .empty       (RSPEmpty),
        .fault       (rsp_fault)
    );

    assign StackFault = msp_fault | rsp_fault;

    // The return stack has no second-entry consumer.
    logic unused_rsp_second;
    assign unused_rsp_second = ^rsp_second_addr;

endmodule

// File: tb/tb_stack_pointer_unit.sv
module tb_stack_pointer_unit;

  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  logic        MSPWrite = 1'b0, MSPPop = 1'b0, MSPRegReset = 1'b0;
  logic        RSPWrite = 1'b0, RSPPop = 1'b0, RSPRegReset = 1'b0;
  logic [15:0] MSPAddr, MSPPushAddr, MSPSecondAddr, RSPAddr, RSPPushAddr;
  logic [8:0]  MSPDepth;
  logic [6:0]  RSPDepth;
  logic        MSPEmpty, RSPEmpty, StackFault;

  stack_pointer_unit dut (
    .CLK           (CLK),
    .Rst           (Rst),
    .MSPWrite      (MSPWrite),
    .MSPPop        (MSPPop),
    .MSPRegReset   (MSPRegReset),
    .RSPWrite      (RSPWrite),
    .RSPPop        (RSPPop),
    .RSPRegReset   (RSPRegReset),
    .MSPAddr       (MSPAddr),
    .MSPPushAddr   (MSPPushAddr),
    .MSPSecondAddr (MSPSecondAddr),
    .RSPAddr       (RSPAddr),
    .RSPPushAddr   (RSPPushAddr),
    .MSPDepth      (MSPDepth),
    .RSPDepth      (RSPDepth),
    .MSPEmpty      (MSPEmpty),
    .RSPEmpty      (RSPEmpty),
    .StackFault    (StackFault)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

`ifdef STACK_FAULT_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Stack s: 0 = main, 1 = return. Pointer = base minus entries pushed.
  int n_asserts = 0;
  int n_fail    = 0;
  int base_v[2] = '{32'h7FFF, 32'h7EFF};
  int max_d[2]  = '{256, 64};
  int m_ptr[2];
  int m_dep[2];
  bit m_flt[2];

  function automatic int wrap16(input int v);
    return (v + 65536) % 65536;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = base_v[s];
      m_dep[s] = 0;
      m_flt[s] = 1'b0;
    end
  endtask

  task automatic model_apply(input int s, input bit w, input bit p, input bit r);
    bool_ops: begin
      if (r) begin
        m_ptr[s] = base_v[s];
        m_dep[s] = 0;
        m_flt[s] = 1'b0;
      end else if (w && !p) begin
        if (m_dep[s] == max_d[s]) begin
          if (TRAP) m_flt[s] = 1'b1;
          else      m_ptr[s] = wrap16(m_ptr[s] - 1);
        end else begin
          m_ptr[s] = wrap16(m_ptr[s] - 1);
          m_dep[s] = m_dep[s] + 1;
        end
      end else if (w && p) begin
        if (m_dep[s] == 0) begin
          if (TRAP) m_flt[s] = 1'b1;
          else      m_ptr[s] = wrap16(m_ptr[s] + 1);
        end else begin
          m_ptr[s] = wrap16(m_ptr[s] + 1);
          m_dep[s] = m_dep[s] - 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".MSPAddr"},       32'(MSPAddr),       32'(m_ptr[0]));
    check({tag, ".MSPPushAddr"},   32'(MSPPushAddr),   32'(wrap16(m_ptr[0] - 1)));
    check({tag, ".MSPSecondAddr"}, 32'(MSPSecondAddr), 32'(wrap16(m_ptr[0] + 1)));
    check({tag, ".RSPAddr"},       32'(RSPAddr),       32'(m_ptr[1]));
    check({tag, ".RSPPushAddr"},   32'(RSPPushAddr),   32'(wrap16(m_ptr[1] - 1)));
    check({tag, ".MSPDepth"},      32'(MSPDepth),      32'(m_dep[0]));
    check({tag, ".RSPDepth"},      32'(RSPDepth),      32'(m_dep[1]));
    check({tag, ".MSPEmpty"},      32'(MSPEmpty),      32'(m_dep[0] == 0));
    check({tag, ".RSPEmpty"},      32'(RSPEmpty),      32'(m_dep[1] == 0));
    check({tag, ".StackFault"},    32'(StackFault),    32'(m_flt[0] | m_flt[1]));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; drives, takes one rising edge,
  // updates the model, checks 1 ns later, returns on the next falling edge.
  task automatic cycle(input string tag,
                       input bit mw, input bit mp, input bit mr,
                       input bit rw, input bit rp, input bit rr);
    MSPWrite = mw; MSPPop = mp; MSPRegReset = mr;
    RSPWrite = rw; RSPPop = rp; RSPRegReset = rr;
    @(posedge CLK);
    model_apply(0, mw, mp, mr);
    model_apply(1, rw, rp, rr);
    #1;
    check_all(tag);
    @(negedge CLK);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset held for a couple of cycles
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("in_reset");
    Rst = 1'b0;
    repeat (5) cycle("idle", 0, 0, 0, 0, 0, 0);
    check("idle.MSPAddr_lit", 32'(MSPAddr), 32'h7FFF);
    check("idle.RSPAddr_lit", 32'(RSPAddr), 32'h7EFF);

    // Three MSP pushes, one pop
    repeat (3) cycle("msp_push", 1, 0, 0, 0, 0, 0);
    check("push3.MSPAddr_lit",     32'(MSPAddr),       32'h7FFC);
    check("push3.MSPPushAddr_lit", 32'(MSPPushAddr),   32'h7FFB);
    check("push3.MSPSecond_lit",   32'(MSPSecondAddr), 32'h7FFD);
    check("push3.MSPDepth_lit",    32'(MSPDepth),      32'd3);
    cycle("msp_pop", 1, 1, 0, 0, 0, 0);
    check("pop1.MSPAddr_lit",  32'(MSPAddr),  32'h7FFD);
    check("pop1.MSPDepth_lit", 32'(MSPDepth), 32'd2);

    // RSP to depth 1, then simultaneous MSP push and RSP pop
    cycle("rsp_push", 0, 0, 0, 1, 0, 0);
    cycle("mixed", 1, 0, 0, 1, 1, 0);
    check("mixed.RSPAddr_lit",  32'(RSPAddr),  32'h7EFF);
    check("mixed.RSPEmpty_lit", 32'(RSPEmpty), 32'd1);
    check("mixed.MSPAddr_lit",  32'(MSPAddr),  32'h7FFC);

    // Reach depth 5, then all three MSP strobes together: reload wins
    repeat (2) cycle("msp_push", 1, 0, 0, 0, 0, 0);
    check("depth5.MSPDepth_lit", 32'(MSPDepth), 32'd5);
    cycle("reload_wins", 1, 1, 1, 0, 0, 0);
    check("reload.MSPAddr_lit",  32'(MSPAddr),  32'h7FFF);
    check("reload.MSPDepth_lit", 32'(MSPDepth), 32'd0);

    // Pop strobe without write: no effect
    cycle("push_then", 1, 0, 0, 0, 0, 0);
    cycle("pop_no_write", 0, 1, 0, 0, 1, 0);
    check("pop_no_write.MSPDepth_lit", 32'(MSPDepth), 32'd1);
    cycle("msp_pop", 1, 1, 0, 0, 0, 0);

    // Underflow on the empty main stack
    cycle("msp_underflow", 1, 1, 0, 0, 0, 0);
    if (TRAP) begin
      check("uflow.MSPAddr_lit",    32'(MSPAddr),    32'h7FFF);
      check("uflow.StackFault_lit", 32'(StackFault), 32'd1);
    end else begin
      check("uflow.MSPAddr_lit",    32'(MSPAddr),    32'h8000);
      check("uflow.StackFault_lit", 32'(StackFault), 32'd0);
    end

    // 65 return-stack pushes from empty: the last one overflows
    repeat (65) cycle("rsp_fill", 0, 0, 0, 1, 0, 0);
    check("rfull.RSPDepth_lit", 32'(RSPDepth), 32'd64);
    check("rfull.RSPAddr_lit",  32'(RSPAddr),  TRAP ? 32'h7EBF : 32'h7EBE);

    // Clearing the main stack leaves the return-stack fault visible
    cycle("msp_regreset", 0, 0, 1, 0, 0, 0);
    check("mclr.StackFault_lit", 32'(StackFault), 32'(TRAP));
    cycle("rsp_regreset", 0, 0, 0, 0, 0, 1);
    check("rclr.StackFault_lit", 32'(StackFault), 32'd0);

    // Main stack to full depth, back-to-back push/pop at the top, overflow
    repeat (255) cycle("msp_fill", 1, 0, 0, 0, 0, 0);
    cycle("msp_to_full", 1, 0, 0, 0, 0, 0);
    check("mfull.MSPDepth_lit", 32'(MSPDepth), 32'd256);
    cycle("msp_pop_full", 1, 1, 0, 0, 0, 0);
    check("mfull_pop.MSPDepth_lit", 32'(MSPDepth), 32'd255);
    cycle("msp_push_full", 1, 0, 0, 0, 0, 0);
    cycle("msp_overflow", 1, 0, 0, 0, 0, 0);
    check("moflow.MSPDepth_lit", 32'(MSPDepth), 32'd256);
    cycle("msp_regreset", 0, 0, 1, 0, 0, 0);

    // Randomised strobes on both stacks
    for (int i = 0; i < 400; i++) begin
      cycle("random",
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset in the middle of a push burst
    repeat (4) cycle("burst", 1, 0, 0, 1, 0, 0);
    MSPWrite = 1'b1; MSPPop = 1'b0; RSPWrite = 1'b1; RSPPop = 1'b0;
    @(posedge CLK);
    model_apply(0, 1, 0, 0);
    model_apply(1, 1, 0, 0);
    #2;
    Rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.MSPAddr_lit", 32'(MSPAddr), 32'h7FFF);
    @(negedge CLK);
    check_all("async_rst_hold");
    Rst = 1'b0;
    cycle("post_rst", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
